// File: rtl/pipe_chain.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_chain
//  Description : Elastic pipeline register chain of DEPTH stages with a
//                valid/ready handshake at both ends, bubble collapse, global
//                stall and per-stage flush. Optional performance counters are
//                built only when PIPE_CHAIN_PERF_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_chain #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 5,
    parameter int CNT_W  = 32
) (
    input  logic                         Clk,
    input  logic                         Rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DATA_W-1:0]            in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_W-1:0]            out_data,
    input  logic                         Stall,
    input  logic [DEPTH-1:0]             Flush,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy,
    output logic [CNT_W-1:0]             stall_cycles,
    output logic [CNT_W-1:0]             bubble_cycles
);

    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0]  r_v;
    logic [DATA_W-1:0] r_d [DEPTH];

    logic [DEPTH:0]    w_rdy;
    logic [DEPTH-1:0]  w_src_v;
    logic [DATA_W-1:0] w_src_d [DEPTH];
    logic [OCC_W-1:0]  w_occ;

    // Source of each stage: the upstream port for stage 0, else the previous stage.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_src
            if (gi == 0) begin : g_first
                assign w_src_v[gi] = in_valid;
                assign w_src_d[gi] = in_data;
            end else begin : g_rest
                assign w_src_v[gi] = r_v[gi-1];
                assign w_src_d[gi] = r_d[gi-1];
            end
        end
    endgenerate

    // Ready ripples from the output back to the input; an empty stage is always
    // ready so bubbles collapse even when the stage ahead of it is blocked.
    always_comb begin
        w_rdy        = '0;
        w_rdy[DEPTH] = out_ready & ~Stall;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            w_rdy[i] = (~r_v[i] | w_rdy[i+1]) & ~Stall;
        end
    end

    // Stage registers: flush clears the valid bit and wins over load/hold; the
    // payload still loads on ready since its contents under v=0 are don't-care.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_v <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_d[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (Flush[i]) begin
                    r_v[i] <= 1'b0;
                end else if (w_rdy[i]) begin
                    r_v[i] <= w_src_v[i];
                end
                if (w_rdy[i]) begin
                    r_d[i] <= w_src_d[i];
                end
            end
        end
    end

    // Number of valid stages, taken straight from the registered state.
    always_comb begin
        w_occ = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_occ = w_occ + OCC_W'(r_v[i]);
        end
    end

    assign in_ready  = w_rdy[0];
    assign out_valid = r_v[DEPTH-1] & ~Stall;
    assign out_data  = r_d[DEPTH-1];
    assign occupancy = w_occ;

`ifdef PIPE_CHAIN_PERF_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_bubble_cnt;

    // Saturating event counters for stalled cycles and starved-output cycles.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if (Stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (out_ready && !out_valid && (r_bubble_cnt != {CNT_W{1'b1}})) begin
                r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
            end
        end
    end

    assign stall_cycles  = r_stall_cnt;
    assign bubble_cycles = r_bubble_cnt;
`else
    assign stall_cycles  = '0;
    assign bubble_cycles = '0;
`endif

endmodule
`default_nettype wire
